pong_game_state: RTL and testbench
==================================

# pong_game_state

Per-frame game-logic stage for NTSC Pong. Sits directly upstream of the NTSC scan/video generator and supplies the ball and paddle positions it renders. Once per video frame, the block:
- samples four player buttons,
- moves both paddles,
- moves the ball, handling wall bounces and paddle hits,
- keeps score and sequences serve / play / game-over.

All positions are in renderer cell units: X cell = scanX/4, Y cell = scanY/8.

## Interface

Parameters:
- BALL_MIN_X, 11: leftmost ball column; the left paddle hit/miss test happens here.
- BALL_MAX_X, 55: rightmost ball column; the right paddle hit/miss test happens here.
- BALL_MIN_Y, 2: top ball row.
- BALL_MAX_Y, 30: bottom ball row.
- PADDLE_HEIGHT, 4: paddle length in rows.
- PADDLE_MIN_Y, 2: minimum paddle top row.
- PADDLE_MAX_Y, 27: maximum paddle top row. Must equal BALL_MAX_Y-PADDLE_HEIGHT+1.
- SERVE_DELAY, 60: frames of hidden ball before play resumes.
- SCORE_MAX, 9: score that ends the game.

Ports:
- ntscClock  in  1  3.58 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frameTick  in  1  frame strobe from the video timing; the rising edge is the event.
- btnLeftUp, btnLeftDown, btnRightUp, btnRightDown  in  1 each  raw asynchronous buttons, active-high.
- ballX  out  6  ball column.
- ballY  out  6  ball row.
- paddleLeftY  out  6  left paddle top row.
- paddleRightY  out  6  right paddle top row.
- scoreLeft  out  4  left player score, 0..SCORE_MAX.
- scoreRight  out  4  right player score, 0..SCORE_MAX.
- ballVisible  out  1  renderer draws the ball only when this is 1.
- gameOver  out  1  1 once either score reaches SCORE_MAX.

## Operation

Reset values:
- ballX = (BALL_MIN_X+BALL_MAX_X)/2 = 33; ballY = 16.
- paddleLeftY = paddleRightY = 15.
- scoreLeft = scoreRight = 0.
- dirX = RIGHT, dirY = DOWN.
- State SERVE, serveCount = SERVE_DELAY.
- ballVisible = 0, gameOver = 0.
- Synchronizer and edge-detect flops cleared.

Inputs:
- Each button passes through a 2-flop synchronizer.
- frame = frameTick & !frameTickPrev. A level held high counts as one frame.
- Nothing changes except on a frame cycle.

Paddles (all states except GAME_OVER):
- Up only: top row -1, saturating at PADDLE_MIN_Y.
- Down only: top row +1, saturating at PADDLE_MAX_Y.
- Both or neither: hold.

State SERVE:
- ballVisible = 0; ball held at the centre (33,16).
- Each frame: if serveCount==0, go to PLAY, set ballVisible=1 and reload serveCount; otherwise serveCount -1.
- The ball therefore appears on the (SERVE_DELAY+1)th frame after entering SERVE.

State PLAY, each frame. All tests use pre-update values, including the pre-move paddle position.
- Vertical:
  - Moving DOWN at BALL_MAX_Y: dirY becomes UP, ballY -1.
  - Moving UP at BALL_MIN_Y: dirY becomes DOWN, ballY +1.
  - Otherwise step ballY in dirY.
- Horizontal, moving LEFT at BALL_MIN_X:
  - Hit when paddleLeftY ≤ ballY ≤ paddleLeftY+PADDLE_HEIGHT-1: dirX becomes RIGHT, ballX +1, and the vertical update still applies.
  - Miss: scoreRight +1, ball recentred, dirX = LEFT (serve toward the conceding player), go to SERVE. The vertical update is discarded and dirY is kept.
- Horizontal, moving RIGHT at BALL_MAX_X: mirror of the left case using paddleRightY. A miss increments scoreLeft and sets dirX = RIGHT.
- Otherwise step ballX in dirX.

State GAME_OVER:
- Entered instead of SERVE when a miss brings a score to SCORE_MAX.
- gameOver=1, ballVisible=0.
- All outputs frozen until reset_n.
- Scores never exceed SCORE_MAX.

Widths: all position arithmetic is 6-bit. The saturation and bounce rules above guarantee no wrap-around.

## Timing

- Every output is a register.
- All outputs update on the ntscClock edge where the frame condition is true, and are visible one cycle after the frameTick rising edge reaches the edge detector.
- Button latency: 2 cycles of synchronizer, plus up to one frame of wait for the next update.
- reset_n asserted at any time, including mid-frame or mid-serve, forces all reset values immediately and asynchronously.
- On reset release, the first frame edge can only be detected after frameTickPrev has registered a 0.

## Test plan

- Serve timing: reset, then pulse frameTick 61 times → ballVisible rises on tick 61 with ball at (33,16). The next tick gives (34,17).
- Bottom bounce: ball at (40,30), dirY=DOWN, dirX=RIGHT, one tick → (41,29), dirY=UP.
- Left hit: paddleLeftY=15, ball at (11,17) moving LEFT/DOWN, one tick → (12,18), dirX=RIGHT, scores unchanged.
- Left miss: paddleLeftY=2, ball at (11,20) moving LEFT, one tick → scoreRight=1, ballVisible=0, ball at (33,16), state SERVE.
- Paddle clamp and held level:
  - btnLeftUp held for 20 ticks from reset → paddleLeftY saturates at 2.
  - frameTick held high for 100 cycles → exactly one update.
- Game over and reset: scoreLeft=8, then a right-side miss → scoreLeft=9, gameOver=1, and further ticks and buttons change nothing. Pulsing reset_n mid-play restores every reset value at once.

Source files
------------

// File: rtl/pong_game_state.sv
// Per-frame Pong game logic: paddles, ball motion, scoring and serve sequencing.
// All positions are in renderer cell units and update once per video frame.
module pong_game_state #(
  parameter int BALL_MIN_X    = 11,
  parameter int BALL_MAX_X    = 55,
  parameter int BALL_MIN_Y    = 2,
  parameter int BALL_MAX_Y    = 30,
  parameter int PADDLE_HEIGHT = 4,
  parameter int PADDLE_MIN_Y  = 2,
  parameter int PADDLE_MAX_Y  = 27,
  parameter int SERVE_DELAY   = 60,
  parameter int SCORE_MAX     = 9
) (
  input  logic       ntscClock,
  input  logic       reset_n,
  input  logic       frameTick,
  input  logic       btnLeftUp,
  input  logic       btnLeftDown,
  input  logic       btnRightUp,
  input  logic       btnRightDown,
  output logic [5:0] ballX,
  output logic [5:0] ballY,
  output logic [5:0] paddleLeftY,
  output logic [5:0] paddleRightY,
  output logic [3:0] scoreLeft,
  output logic [3:0] scoreRight,
  output logic       ballVisible,
  output logic       gameOver
);

  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic [5:0] CENTER_X = 6'((BALL_MIN_X + BALL_MAX_X) / 2);
  localparam logic [5:0] CENTER_Y = 6'((BALL_MIN_Y + BALL_MAX_Y) / 2);
  localparam logic [5:0] PAD_INIT = 6'((PADDLE_MIN_Y + PADDLE_MAX_Y + 1) / 2);
  localparam logic [5:0] MIN_X    = 6'(BALL_MIN_X);
  localparam logic [5:0] MAX_X    = 6'(BALL_MAX_X);
  localparam logic [5:0] MIN_Y    = 6'(BALL_MIN_Y);
  localparam logic [5:0] MAX_Y    = 6'(BALL_MAX_Y);
  localparam logic [5:0] PAD_MIN  = 6'(PADDLE_MIN_Y);
  localparam logic [5:0] PAD_MAX  = 6'(PADDLE_MAX_Y);
  localparam logic [5:0] PAD_SPAN = 6'(PADDLE_HEIGHT - 1);
  localparam logic [3:0] SC_MAX   = 4'(SCORE_MAX);
  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY);

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    GAME_OVER
  } state_t;

  typedef enum logic {
    LEFT,
    RIGHT
  } dirX_t;

  typedef enum logic {
    UP,
    DOWN
  } dirY_t;

  state_t        state;
  dirX_t         dirX;
  dirX_t         nextDirX;
  dirY_t         dirY;
  dirY_t         nextDirY;
  logic [CW-1:0] serveCount;
  logic          frameTickPrev;
  logic          frame;
  logic [3:0]    btnMeta;
  logic [3:0]    btnSync;
  logic [5:0]    nextX;
  logic [5:0]    nextY;
  logic [5:0]    nextPadL;
  logic [5:0]    nextPadR;
  logic          leftEdge;
  logic          rightEdge;
  logic          leftHit;
  logic          rightHit;
  logic          leftMiss;
  logic          rightMiss;
  logic [3:0]    scoreLeftInc;
  logic [3:0]    scoreRightInc;

  function automatic logic [5:0] movePaddle(
    input logic [5:0] y,
    input logic       up,
    input logic       dn
  );
    logic [5:0] r;
    r = y;
    if (up && !dn && y > PAD_MIN) r = y - 6'd1;
    if (dn && !up && y < PAD_MAX) r = y + 6'd1;
    return r;
  endfunction

  assign frame = frameTick & ~frameTickPrev;

  assign nextPadL = movePaddle(paddleLeftY, btnSync[3], btnSync[2]);
  assign nextPadR = movePaddle(paddleRightY, btnSync[1], btnSync[0]);

  assign leftEdge  = (dirX == LEFT) && (ballX == MIN_X);
  assign rightEdge = (dirX == RIGHT) && (ballX == MAX_X);

  // Hit window uses the paddle position from before this frame's move.
  assign leftHit = (ballY >= paddleLeftY)
                 && (ballY <= paddleLeftY + PAD_SPAN);
  assign rightHit = (ballY >= paddleRightY)
                  && (ballY <= paddleRightY + PAD_SPAN);

  assign leftMiss  = leftEdge && !leftHit;
  assign rightMiss = rightEdge && !rightHit;

  assign scoreLeftInc  = scoreLeft + 4'd1;
  assign scoreRightInc = scoreRight + 4'd1;

  always_comb begin
    nextY    = ballY;
    nextDirY = dirY;
    if (dirY == DOWN) begin
      if (ballY == MAX_Y) begin
        nextDirY = UP;
        nextY    = ballY - 6'd1;
      end else begin
        nextY = ballY + 6'd1;
      end
    end else begin
      if (ballY == MIN_Y) begin
        nextDirY = DOWN;
        nextY    = ballY + 6'd1;
      end else begin
        nextY = ballY - 6'd1;
      end
    end
  end

  always_comb begin
    nextX    = ballX;
    nextDirX = dirX;
    unique case (1'b1)
      leftEdge: begin
        nextDirX = RIGHT;
        nextX    = ballX + 6'd1;
      end
      rightEdge: begin
        nextDirX = LEFT;
        nextX    = ballX - 6'd1;
      end
      default: begin
        if (dirX == RIGHT) nextX = ballX + 6'd1;
        else               nextX = ballX - 6'd1;
      end
    endcase
  end

  always_ff @(posedge ntscClock or negedge reset_n) begin
    if (!reset_n) begin
      frameTickPrev <= 1'b0;
      btnMeta       <= 4'd0;
      btnSync       <= 4'd0;
      state         <= SERVE;
      serveCount    <= SERVE_LOAD;
      dirX          <= RIGHT;
      dirY          <= DOWN;
      ballX         <= CENTER_X;
      ballY         <= CENTER_Y;
      paddleLeftY   <= PAD_INIT;
      paddleRightY  <= PAD_INIT;
      scoreLeft     <= 4'd0;
      scoreRight    <= 4'd0;
      ballVisible   <= 1'b0;
      gameOver      <= 1'b0;
    end else begin
      frameTickPrev <= frameTick;
      btnMeta <= {btnLeftUp, btnLeftDown, btnRightUp, btnRightDown};
      btnSync <= btnMeta;
      if (frame && state != GAME_OVER) begin
        paddleLeftY  <= nextPadL;
        paddleRightY <= nextPadR;
        unique case (state)
          SERVE: begin
            if (serveCount == '0) begin
              state       <= PLAY;
              ballVisible <= 1'b1;
              serveCount  <= SERVE_LOAD;
            end else begin
              serveCount <= serveCount - CW'(1);
            end
          end
          PLAY: begin
            unique case (1'b1)
              leftMiss: begin
                scoreRight  <= scoreRightInc;
                ballX       <= CENTER_X;
                ballY       <= CENTER_Y;
                dirX        <= LEFT;
                ballVisible <= 1'b0;
                if (scoreRightInc == SC_MAX) begin
                  state    <= GAME_OVER;
                  gameOver <= 1'b1;
                end else begin
                  state <= SERVE;
                end
              end
              rightMiss: begin
                scoreLeft   <= scoreLeftInc;
                ballX       <= CENTER_X;
                ballY       <= CENTER_Y;
                dirX        <= RIGHT;
                ballVisible <= 1'b0;
                if (scoreLeftInc == SC_MAX) begin
                  state    <= GAME_OVER;
                  gameOver <= 1'b1;
                end else begin
                  state <= SERVE;
                end
              end
              default: begin
                ballX <= nextX;
                ballY <= nextY;
                dirX  <= nextDirX;
                dirY  <= nextDirY;
              end
            endcase
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_game_state.sv
// Directed-vector bench for pong_game_state: serve, bounces, hits,
// misses, paddle clamping, held frame level, game over and async reset.
module tb_pong_game_state;

  logic       ntscClock = 1'b0;
  logic       reset_n = 1'b0;
  logic       frameTick = 1'b0;
  logic       btnLeftUp = 1'b0;
  logic       btnLeftDown = 1'b0;
  logic       btnRightUp = 1'b0;
  logic       btnRightDown = 1'b0;
  logic [5:0] ballX;
  logic [5:0] ballY;
  logic [5:0] paddleLeftY;
  logic [5:0] paddleRightY;
  logic [3:0] scoreLeft;
  logic [3:0] scoreRight;
  logic       ballVisible;
  logic       gameOver;

  int nVec = 0;
  int nErr = 0;

  always #5 ntscClock = ~ntscClock;

  pong_game_state dut (
    .ntscClock    (ntscClock),
    .reset_n      (reset_n),
    .frameTick    (frameTick),
    .btnLeftUp    (btnLeftUp),
    .btnLeftDown  (btnLeftDown),
    .btnRightUp   (btnRightUp),
    .btnRightDown (btnRightDown),
    .ballX        (ballX),
    .ballY        (ballY),
    .paddleLeftY  (paddleLeftY),
    .paddleRightY (paddleRightY),
    .scoreLeft    (scoreLeft),
    .scoreRight   (scoreRight),
    .ballVisible  (ballVisible),
    .gameOver     (gameOver)
  );

  typedef struct {
    int         ticks;
    logic [3:0] btn;
    logic [5:0] bx;
    logic [5:0] by;
    logic [5:0] pl;
    logic [5:0] pr;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       vis;
    logic       go;
  } vec_t;

  function automatic vec_t mk(int t, int b, int x, int y, int pl,
                              int pr, int sl, int sr, int vis, int go);
    vec_t v;
    v.ticks = t;
    v.btn   = 4'(b);
    v.bx    = 6'(x);
    v.by    = 6'(y);
    v.pl    = 6'(pl);
    v.pr    = 6'(pr);
    v.sl    = 4'(sl);
    v.sr    = 4'(sr);
    v.vis   = 1'(vis);
    v.go    = 1'(go);
    return v;
  endfunction

  task automatic cmp(string nm, logic [7:0] got, logic [7:0] exp);
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic checkAll(string tag, vec_t v);
    nVec++;
    cmp({tag, " ballX"}, 8'(ballX), 8'(v.bx));
    cmp({tag, " ballY"}, 8'(ballY), 8'(v.by));
    cmp({tag, " paddleLeftY"}, 8'(paddleLeftY), 8'(v.pl));
    cmp({tag, " paddleRightY"}, 8'(paddleRightY), 8'(v.pr));
    cmp({tag, " scoreLeft"}, 8'(scoreLeft), 8'(v.sl));
    cmp({tag, " scoreRight"}, 8'(scoreRight), 8'(v.sr));
    cmp({tag, " ballVisible"}, 8'(ballVisible), 8'(v.vis));
    cmp({tag, " gameOver"}, 8'(gameOver), 8'(v.go));
  endtask

  task automatic setBtn(logic [3:0] b);
    {btnLeftUp, btnLeftDown, btnRightUp, btnRightDown} = b;
    repeat (3) @(negedge ntscClock);
  endtask

  task automatic tick();
    @(negedge ntscClock);
    frameTick = 1'b1;
    @(negedge ntscClock);
    frameTick = 1'b0;
    repeat (3) @(negedge ntscClock);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset();
    @(negedge ntscClock);
    reset_n = 1'b0;
    frameTick = 1'b0;
    {btnLeftUp, btnLeftDown, btnRightUp, btnRightDown} = 4'b0000;
    repeat (2) @(negedge ntscClock);
    reset_n = 1'b1;
    repeat (2) @(negedge ntscClock);
  endtask

  vec_t tbl[23];

  initial begin
    // btn order: {LeftUp, LeftDown, RightUp, RightDown}
    tbl[0]  = mk(0,  'b0000, 33, 16, 15, 15, 0, 0, 0, 0);
    tbl[1]  = mk(5,  'b1001, 33, 16, 10, 20, 0, 0, 0, 0);
    tbl[2]  = mk(8,  'b1000, 33, 16,  2, 20, 0, 0, 0, 0);
    tbl[3]  = mk(7,  'b1000, 33, 16,  2, 20, 0, 0, 0, 0);
    tbl[4]  = mk(40, 'b0000, 33, 16,  2, 20, 0, 0, 0, 0);
    tbl[5]  = mk(1,  'b0000, 33, 16,  2, 20, 0, 0, 1, 0);
    tbl[6]  = mk(1,  'b0000, 34, 17,  2, 20, 0, 0, 1, 0);
    tbl[7]  = mk(13, 'b0000, 47, 30,  2, 20, 0, 0, 1, 0);
    tbl[8]  = mk(1,  'b0000, 48, 29,  2, 20, 0, 0, 1, 0);
    tbl[9]  = mk(7,  'b0000, 55, 22,  2, 20, 0, 0, 1, 0);
    tbl[10] = mk(1,  'b0000, 54, 21,  2, 20, 0, 0, 1, 0);
    tbl[11] = mk(19, 'b0000, 35,  2,  2, 20, 0, 0, 1, 0);
    tbl[12] = mk(1,  'b0000, 34,  3,  2, 20, 0, 0, 1, 0);
    tbl[13] = mk(23, 'b0000, 11, 26,  2, 20, 0, 0, 1, 0);
    tbl[14] = mk(1,  'b0000, 33, 16,  2, 20, 0, 1, 0, 0);
    tbl[15] = mk(18, 'b0100, 33, 16, 20, 20, 0, 1, 0, 0);
    tbl[16] = mk(42, 'b0000, 33, 16, 20, 20, 0, 1, 0, 0);
    tbl[17] = mk(1,  'b0000, 33, 16, 20, 20, 0, 1, 1, 0);
    tbl[18] = mk(1,  'b0000, 32, 17, 20, 20, 0, 1, 1, 0);
    tbl[19] = mk(13, 'b1100, 19, 30, 20, 20, 0, 1, 1, 0);
    tbl[20] = mk(1,  'b0000, 18, 29, 20, 20, 0, 1, 1, 0);
    tbl[21] = mk(7,  'b0000, 11, 22, 20, 20, 0, 1, 1, 0);
    tbl[22] = mk(1,  'b0000, 12, 21, 20, 20, 0, 1, 1, 0);

    // Held frame level: one paddle step only.
    doReset();
    checkAll("reset", mk(0, 0, 33, 16, 15, 15, 0, 0, 0, 0));
    setBtn(4'b1000);
    @(negedge ntscClock);
    frameTick = 1'b1;
    repeat (100) @(negedge ntscClock);
    frameTick = 1'b0;
    repeat (3) @(negedge ntscClock);
    checkAll("heldLevel", mk(0, 0, 33, 16, 14, 15, 0, 0, 0, 0));

    // Serve, bounces, right hit, left miss, left hit.
    doReset();
    for (int i = 0; i < 23; i++) begin
      setBtn(tbl[i].btn);
      ticks(tbl[i].ticks);
      checkAll($sformatf("v%0d", i), tbl[i]);
    end

    // Nine right-side misses, one every 84 frames, end the game.
    doReset();
    for (int n = 1; n <= 9; n++) begin
      ticks(84);
      checkAll($sformatf("miss%0d", n),
               mk(0, 0, 33, 16, 15, 15, n, 0, 0, (n == 9) ? 1 : 0));
    end
    setBtn(4'b0101);
    ticks(10);
    checkAll("frozen", mk(0, 0, 33, 16, 15, 15, 9, 0, 0, 1));
    setBtn(4'b1010);
    ticks(70);
    checkAll("frozen2", mk(0, 0, 33, 16, 15, 15, 9, 0, 0, 1));

    // Asynchronous reset in the middle of play.
    doReset();
    setBtn(4'b1000);
    ticks(70);
    checkAll("midPlay", mk(0, 0, 42, 25, 2, 15, 0, 0, 1, 0));
    @(negedge ntscClock);
    #2 reset_n = 1'b0;
    #1 checkAll("asyncReset", mk(0, 0, 33, 16, 15, 15, 0, 0, 0, 0));
    {btnLeftUp, btnLeftDown, btnRightUp, btnRightDown} = 4'b0000;
    repeat (2) @(negedge ntscClock);
    reset_n = 1'b1;
    repeat (2) @(negedge ntscClock);
    ticks(60);
    checkAll("reserve60", mk(0, 0, 33, 16, 15, 15, 0, 0, 0, 0));
    tick();
    checkAll("reserve61", mk(0, 0, 33, 16, 15, 15, 0, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
